// File: rtl/sdf8_output_reorder_if.sv
// Handshake bundle between the SDF8 NTT pipeline, the output reorder buffer and the downstream consumer.
// err_overflow is present only when REORDER_ERR_EN is defined.
interface sdf8_output_reorder_if #(
  parameter int DATA_W = 16
);
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              out_last;
`ifdef REORDER_ERR_EN
  logic              err_overflow;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, err_overflow
  );
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, err_overflow
  );
`else
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
`endif
endinterface

// File: rtl/sdf8_output_reorder.sv
// Ping-pong reorder buffer: frames arrive in bit-reversed order and leave in natural order.
// Optional sticky overflow flag enabled by defining REORDER_ERR_EN.
module sdf8_output_reorder #(
  parameter int DATA_W = 16,
  parameter int N      = 8,
  parameter int LOG2N  = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  sdf8_output_reorder_if.slave bus
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = k[LOG2N-1-i];
    end
    return r;
  endfunction

  logic [DATA_W-1:0] mem [2][N];

  logic             wr_bank;
  logic [LOG2N-1:0] wr_cnt;
  logic             rd_bank;
  logic [LOG2N-1:0] rd_cnt;
  logic [1:0]       full;
  logic [1:0]       full_nxt;

  logic in_ready;
  logic out_valid;
  logic wr_fire;
  logic rd_fire;
  logic wr_wrap;
  logic rd_wrap;

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];

  // flush cancels any transfer presented in the same cycle
  assign wr_fire = bus.in_valid && in_ready && !bus.flush;
  assign rd_fire = out_valid && bus.out_ready && !bus.flush;
  assign wr_wrap = wr_fire && (wr_cnt == LAST);
  assign rd_wrap = rd_fire && (rd_cnt == LAST);

  // Set and clear always address different banks, so both may apply in one cycle.
  always_comb begin
    full_nxt = full;
    if (wr_wrap) full_nxt[wr_bank] = 1'b1;
    if (rd_wrap) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
      full    <= 2'b00;
    end else if (bus.flush) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
      full    <= 2'b00;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_wrap) wr_bank <= !wr_bank;
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_wrap) rd_bank <= !rd_bank;
      end
    end
  end

  // Coefficient storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank][bitrev(wr_cnt)] <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? mem[rd_bank][rd_cnt] : '0;
  assign bus.out_last  = out_valid && (rd_cnt == LAST);

`ifdef REORDER_ERR_EN
  logic err_q;

  // Sticky until rst_n; flush deliberately leaves it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (bus.in_valid && !in_ready) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_overflow = err_q;
`endif

endmodule

// File: tb/tb_sdf8_output_reorder.sv
// Directed bench for sdf8_output_reorder: reorder, back-to-back, backpressure/overflow, flush, async reset.
module tb_sdf8_output_reorder;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  sdf8_output_reorder_if #(.DATA_W(16)) bus ();

  sdf8_output_reorder #(.DATA_W(16), .N(8), .LOG2N(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // natural-order position k holds input index bitrev(k)
  int perm [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  task automatic test_reset();
    rst_n = 1'b0;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_tests++;
    if (bus.out_data !== 16'd0) begin n_fail++; $display("FAIL reset_out_data got=%0d exp=0", bus.out_data); end
    n_tests++;
    if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got=%b exp=0", bus.out_last); end
`ifdef REORDER_ERR_EN
    n_tests++;
    if (bus.err_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", bus.err_overflow); end
`endif
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  // Writes one frame starting at base, then reads it back, checking latency and order.
  task automatic test_frame(input int base, input string tag);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 17; c++) begin
      @(posedge clk); #1;
      bus.in_valid = (c < 8);
      bus.in_data  = 16'(base + c);
      #1;
      n_tests++;
      if (bus.out_valid !== (c >= 8 && c < 16)) begin
        n_fail++; $display("FAIL %s_valid c=%0d got=%b exp=%b", tag, c, bus.out_valid, (c >= 8 && c < 16));
      end
      if (c >= 8 && c < 16) begin
        n_tests++;
        if (bus.out_data !== 16'(base + perm[c-8])) begin
          n_fail++; $display("FAIL %s_data k=%0d got=%0d exp=%0d", tag, c - 8, bus.out_data, base + perm[c-8]);
        end
        n_tests++;
        if (bus.out_last !== (c == 15)) begin
          n_fail++; $display("FAIL %s_last k=%0d got=%b exp=%b", tag, c - 8, bus.out_last, (c == 15));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_d;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      bus.in_valid = (c < 16);
      bus.in_data  = 16'((c < 8) ? 10 + c : 20 + c - 8);
      #1;
      if (c < 16) begin
        n_tests++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready c=%0d got=%b exp=1", c, bus.in_ready); end
      end
      n_tests++;
      if (bus.out_valid !== (c >= 8 && c < 24)) begin
        n_fail++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, bus.out_valid, (c >= 8 && c < 24));
      end
      if (c >= 8 && c < 24) begin
        exp_d = ((c < 16) ? 10 : 20) + perm[(c - 8) % 8];
        n_tests++;
        if (bus.out_data !== 16'(exp_d)) begin
          n_fail++; $display("FAIL b2b_data c=%0d got=%0d exp=%0d", c, bus.out_data, exp_d);
        end
      end
    end
  endtask

  task automatic test_backpressure_overflow();
    int exp_d;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(40 + c);
      #1;
      n_tests++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready c=%0d got=%b exp=1", c, bus.in_ready); end
    end
    @(posedge clk); #1; bus.in_valid = 1'b0; #1;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready got=%b exp=0", bus.in_ready); end
    n_tests++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full_out_valid got=%b exp=1", bus.out_valid); end
    // overflow attempt with data 99 while both banks are full
    @(posedge clk); #1; bus.in_valid = 1'b1; bus.in_data = 16'd99; #1;
`ifdef REORDER_ERR_EN
    n_tests++;
    if (bus.err_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_err_early got=%b exp=0", bus.err_overflow); end
`endif
    @(posedge clk); #1; bus.in_valid = 1'b0; bus.out_ready = 1'b1; #1;
    for (int r = 0; r < 16; r++) begin
      if (r > 0) begin @(posedge clk); #2; end
      exp_d = ((r < 8) ? 40 : 48) + perm[r % 8];
      n_tests++;
      if (bus.out_data !== 16'(exp_d)) begin n_fail++; $display("FAIL bp_data r=%0d got=%0d exp=%0d", r, bus.out_data, exp_d); end
      n_tests++;
      if (bus.out_last !== (r % 8 == 7)) begin n_fail++; $display("FAIL bp_last r=%0d got=%b exp=%b", r, bus.out_last, (r % 8 == 7)); end
      n_tests++;
      if (bus.in_ready !== (r >= 8)) begin n_fail++; $display("FAIL bp_in_ready_ret r=%0d got=%b exp=%b", r, bus.in_ready, (r >= 8)); end
`ifdef REORDER_ERR_EN
      n_tests++;
      if (bus.err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_err_sticky r=%0d got=%b exp=1", r, bus.err_overflow); end
`endif
    end
    @(posedge clk); #2;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 21; c++) begin
      @(posedge clk); #1;
      bus.flush    = (c == 4);
      bus.in_valid = (c < 13);
      bus.in_data  = 16'((c < 5) ? 60 + c : 30 + c - 5);
      #1;
      n_tests++;
      if (bus.out_valid !== (c >= 13)) begin
        n_fail++; $display("FAIL flush_valid c=%0d got=%b exp=%b", c, bus.out_valid, (c >= 13));
      end
      if (c >= 13) begin
        n_tests++;
        if (bus.out_data !== 16'(30 + perm[c-13])) begin
          n_fail++; $display("FAIL flush_data k=%0d got=%0d exp=%0d", c - 13, bus.out_data, 30 + perm[c-13]);
        end
      end
`ifdef REORDER_ERR_EN
      if (c == 5) begin
        n_tests++;
        if (bus.err_overflow !== 1'b1) begin n_fail++; $display("FAIL flush_keeps_err got=%b exp=1", bus.err_overflow); end
      end
`endif
    end
    @(posedge clk); #1; bus.flush = 1'b0; bus.in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      bus.in_valid = (c < 8);
      bus.in_data  = 16'(70 + c);
    end
    #1;
    n_tests++;
    if (bus.out_data !== 16'd76) begin n_fail++; $display("FAIL arst_pre_data got=%0d exp=76", bus.out_data); end
    #1; rst_n = 1'b0; #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid got=%b exp=0", bus.out_valid); end
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready got=%b exp=1", bus.in_ready); end
`ifdef REORDER_ERR_EN
    n_tests++;
    if (bus.err_overflow !== 1'b0) begin n_fail++; $display("FAIL arst_err got=%b exp=0", bus.err_overflow); end
`endif
    @(posedge clk); #1; rst_n = 1'b1;
    test_frame(80, "post_rst");
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_frame(10, "frame");
    test_back_to_back();
    test_backpressure_overflow();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdf8_output_reorder.md
Name: sdf8_output_reorder

Overview:
- Output stage of the 8-point SDF NTT pipeline. The pipeline emits coefficients in bit-reversed order; this block writes each frame into a ping-pong buffer at bit-reversed addresses and reads it back in natural order.
- Valid/ready on both sides. Double buffering allows back-to-back frames with no bubbles when out_ready is held high.

Parameters:
- DATA_W, 16, coefficient width in bits.
- N, 8, frame length in coefficients; must be a power of 2, at least 2.
- LOG2N, 3, log2(N); used for counter and address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of counters and bank state.
- in_valid  in  1  input coefficient valid (from the NTT pipeline datapath).
- in_data  in  DATA_W  coefficient, bit-reversed frame order.
- in_ready  out  1  write bank available.
- out_valid  out  1  output coefficient valid.
- out_data  out  DATA_W  coefficient, natural order.
- out_ready  in  1  downstream accepts.
- out_last  out  1  high with the index N-1 coefficient of each frame.
- err_overflow  out  1  present only with REORDER_ERR_EN.

Behaviour:
- Storage: 2 banks x N x DATA_W register array. Memory is not reset.
- State registers: wr_bank (1b), wr_cnt (LOG2N b), rd_bank (1b), rd_cnt (LOG2N b), full[1:0].
- Reset: all state registers = 0. in_ready=1, out_valid=0, out_data=0, out_last=0, err_overflow=0.
- in_ready = !full[wr_bank], combinational.
- Write on in_valid && in_ready:
  - mem[wr_bank][bitrev(wr_cnt)] <= in_data.
  - wr_cnt increments.
  - When wr_cnt == N-1: wr_cnt wraps to 0, full[wr_bank] <= 1, wr_bank toggles.
- in_valid && !in_ready: data is dropped. No write, no counter change.
- out_valid = full[rd_bank], combinational.
- out_data = mem[rd_bank][rd_cnt] when out_valid, else 0.
- out_last = out_valid && (rd_cnt == N-1).
- Read on out_valid && out_ready:
  - rd_cnt increments.
  - When rd_cnt == N-1: rd_cnt wraps to 0, full[rd_bank] <= 0, rd_bank toggles.
- Latency:
  - First out_valid appears in the cycle after the Nth write of a frame is accepted.
  - Per-coefficient throughput is 1/cycle when out_ready=1.
- Simultaneous events:
  - Set of full[wr_bank] and clear of full[rd_bank] in the same cycle touch different banks. Both take effect.
  - The same bank can never be set and cleared in one cycle, because writes require !full and reads require full.
- Both banks full: in_ready=0 until the read side releases a bank. in_ready returns in the cycle after the out_last handshake.
- flush = 1: next cycle all counters, bank pointers and full flags = 0. flush has priority over a write or read in the same cycle; that transfer is discarded. err_overflow is not cleared by flush.
- rst_n asserted mid-frame: partial frame is abandoned and state returns to reset values immediately.
- bitrev(k): reverse the LOG2N bits of k. For N=8: 0,4,2,6,1,5,3,7.

Optional Feature:
- Macro: REORDER_ERR_EN.
- Defined:
  - Port err_overflow exists.
  - It is a sticky register, set on the clock edge where in_valid && !in_ready.
  - Cleared only by rst_n.
- Not defined:
  - Port and register are absent.
  - Dropped writes are silent.

Test Plan:
- Frame in order: in_data 10,11,12,13,14,15,16,17 on consecutive cycles, out_ready=1 -> out_data 10,14,12,16,11,15,13,17. out_valid first rises 1 cycle after the 17 handshake. out_last is high only with 17.
- Back-to-back frames: 10..17 then 20..27 continuous, out_ready=1 -> 16 contiguous out_valid cycles, second frame reads 20,24,22,26,21,25,23,27. in_ready stays 1 throughout.
- Backpressure: out_ready=0, push 3 frames -> in_ready drops to 0 after 16 accepted writes. Raise out_ready for 8 cycles -> in_ready returns 1 the cycle after out_last.
- Overflow (REORDER_ERR_EN defined): both banks full, in_valid=1 with data 99 -> err_overflow=1 next cycle and stays 1. 99 never appears on out_data.
- Flush mid-frame: write 4 of 8, assert flush with in_valid=1 -> the flush-cycle data is discarded. A subsequent full frame 30..37 outputs 30,34,32,36,31,35,33,37.
- Async reset during readout (rd_cnt=3): out_valid=0 and in_ready=1 immediately. After release, a new frame reorders correctly.
